// File: rtl/ua_receive_if.sv
// Byte-side handshake of the UART receiver: a held byte with valid/ready, plus error pulses.
interface ua_receive_if;
  logic [7:0] DataOut;
  logic       DataOutValid;
  logic       DataOutReady;
  logic       FramingError;
  logic       Overrun;

  modport master (
    output DataOut, DataOutValid, FramingError, Overrun,
    input  DataOutReady
  );

  modport slave (
    input  DataOut, DataOutValid, FramingError, Overrun,
    output DataOutReady
  );
endinterface

// File: rtl/ua_receive.sv
// UART receiver (8N1, LSB first) with a one-byte holding register and framing/overrun pulses.
// Optional macro UA_RECEIVE_MAJORITY_EN: 2-of-3 majority vote around the bit centre.
module ua_receive #(
  parameter int ClockFreq = 100_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       SIn,
  ua_receive_if.master rx
);

  localparam int SYMBOL_EDGE_TIME = ClockFreq / BaudRate;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CW               = $clog2(SYMBOL_EDGE_TIME);

  localparam logic [CW-1:0] CNT_LAST  = CW'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CW-1:0] SAMPLE_M1 = CW'(SAMPLE_TIME - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          prev_q, prev_d;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          fe_q, fe_d;
  logic          ov_q, ov_d;
  logic          sample_en;
  logic          bit_val;
  logic          load;

`ifdef UA_RECEIVE_MAJORITY_EN
  localparam logic [CW-1:0] SAMPLE_M2 = CW'(SAMPLE_TIME - 2);
  localparam logic [CW-1:0] SAMPLE_P0 = CW'(SAMPLE_TIME);

  logic maj0_q, maj0_d;
  logic maj1_q, maj1_d;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // The two early samples are held; the decision lands one cycle after the nominal centre.
  always_comb begin
    maj0_d    = (cnt_q == SAMPLE_M2) ? sync2_q : maj0_q;
    maj1_d    = (cnt_q == SAMPLE_M1) ? sync2_q : maj1_q;
    sample_en = (cnt_q == SAMPLE_P0);
    bit_val   = majority3(maj0_q, maj1_q, sync2_q);
  end

  always_ff @(posedge Clock) begin
    maj0_q <= maj0_d;
    maj1_q <= maj1_d;
  end
`else
  always_comb begin
    sample_en = (cnt_q == SAMPLE_M1);
    bit_val   = sync2_q;
  end
`endif

  always_comb begin
    sync1_d   = SIn;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    state_d   = state_q;
    cnt_d     = (state_q == S_IDLE) ? '0 : ((cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1);
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    fe_d      = 1'b0;
    load      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (sample_en) begin
          state_d   = bit_val ? S_IDLE : S_DATA;
          bit_idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (sample_en) begin
          shreg_d   = {bit_val, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (sample_en) begin
          if (bit_val) begin
            load    = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Wait out a held-low line; the return to idle cannot itself look like a start edge.
        if (sync2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ov_d    = 1'b0;
    if (load) begin
      if (!valid_q || rx.DataOutReady) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end else if (valid_q && rx.DataOutReady) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  always_ff @(posedge Clock) begin
    shreg_q <= shreg_d;
  end

  assign rx.DataOut      = data_q;
  assign rx.DataOutValid = valid_q;
  assign rx.FramingError = fe_q;
  assign rx.Overrun      = ov_q;

endmodule

// File: doc/ua_receive.md
UA_RECEIVE -- requirements
Module: ua_receive

Interface
REQ-001 SHALL have parameter ClockFreq, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BaudRate, default 115_200, serial bit rate in bits/s.
REQ-003 SHALL have port Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port SIn  input  1  asynchronous serial line; idles high.
REQ-006 SHALL have port DataOut  output  8  received byte, LSB first on the line.
REQ-007 SHALL have port DataOutValid  output  1  DataOut holds an unconsumed byte.
REQ-008 SHALL have port DataOutReady  input  1  consumer accepts DataOut this cycle.
REQ-009 SHALL have port FramingError  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port Overrun  output  1  one-cycle pulse: completed byte dropped because the holding register was full.

Function
REQ-011 SHALL derive SymbolEdgeTime = ClockFreq/BaudRate and SampleTime = SymbolEdgeTime/2, both integer-truncated; the cycle counter SHALL be log2(SymbolEdgeTime) bits wide.
REQ-012 SHALL pass SIn through a two-flop synchronizer; all decisions SHALL use the synchronized value (SInSync).
REQ-013 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-014 IDLE: on SInSync high-to-low transition SHALL clear the cycle counter and enter START.
REQ-015 The cycle counter SHALL increment every cycle outside IDLE and wrap to 0 after SymbolEdgeTime-1; the sample point is counter == SampleTime-1.
REQ-016 START: at the sample point, sampled 1 -> IDLE (glitch rejected, no output); sampled 0 -> DATA with bit index 0.
REQ-017 DATA: at each sample point SHALL shift the sampled bit into the MSB of an 8-bit shift register (LSB-first reception); after the 8th bit SHALL enter STOP.
REQ-018 STOP: at the sample point, sampled 1 -> load the byte and enter IDLE; sampled 0 -> assert FramingError for exactly one cycle, discard the byte, and enter BREAK.
REQ-019 BREAK: SHALL remain until SInSync == 1, then enter IDLE; no start is detected while in BREAK.
REQ-020 Byte load SHALL update DataOut and assert DataOutValid on the clock edge following the stop-bit sample cycle (latency 1 cycle).
REQ-021 DataOutValid SHALL stay high and DataOut stable until a cycle with DataOutValid && DataOutReady, after which DataOutValid SHALL be low unless a new byte loads in that same cycle.
REQ-022 Load coinciding with consumption SHALL load the new byte, keep DataOutValid high, and not assert Overrun.
REQ-023 Load while DataOutValid is high and DataOutReady is low SHALL keep the old byte, drop the new one, and pulse Overrun for exactly one cycle.
REQ-024 DataOutReady while DataOutValid is low SHALL have no effect.

Reset
REQ-025 Reset SHALL force state IDLE, cycle counter 0, bit index 0, both synchronizer flops 1, DataOut 8'h00, DataOutValid 0, FramingError 0, Overrun 0.
REQ-026 Reset mid-frame SHALL abandon the frame with no output, no error pulse, and no false start detected on the first cycle after Reset deasserts.

Configuration
REQ-027 With macro UA_RECEIVE_MAJORITY_EN defined, each bit value (start, data, stop) SHALL be the 2-of-3 majority of SInSync at counter values SampleTime-2, SampleTime-1, SampleTime, with the decision taken at counter == SampleTime; without it, the single sample at SampleTime-1 SHALL be used as in REQ-015.

Verification (defaults: SymbolEdgeTime=868, SampleTime=434)
REQ-028 Frame 0x55 with stop=1, DataOutReady held 1 -> DataOut=8'h55, DataOutValid high exactly one cycle, 1 cycle after the stop sample.
REQ-029 Frames 0xA3 then 0x0F back-to-back, DataOutReady held 0 -> DataOut stays 8'hA3, one Overrun pulse at the 0x0F stop sample; a later ready cycle then clears DataOutValid.
REQ-030 Frame 0xFF with stop=0, line held low for 3 bit times then high -> one FramingError pulse, DataOutValid stays 0, next frame 0x12 received correctly.
REQ-031 SIn low pulse of 100 cycles from idle -> returns to IDLE, no output, no error.
REQ-032 Reset asserted for 1 cycle during bit 4 of a frame -> all outputs at reset values, following frame 0x81 received correctly.
REQ-033 With UA_RECEIVE_MAJORITY_EN, single-cycle inverted glitch at counter == SampleTime-1 of every data bit of 0x3C -> DataOut=8'h3C; without the macro the same stimulus -> DataOut=8'hC3.
